// File: rtl/bus_lane_packer_pkg.sv
// Shared constants and helpers for the bus lane packer.
//   clog2          : ceiling log2, used for index, pointer and level widths
//   PAD_DEFAULT    : default pad value, truncated to IN_W by the user
//   keep_all_ones  : keep mask with the low `lanes` bits set (lanes < 64)
package bus_lane_packer_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  localparam logic [63:0] PAD_DEFAULT = '0;

  function automatic logic [63:0] keep_all_ones(input int lanes);
    return (64'd1 << lanes) - 64'd1;
  endfunction

endpackage

// File: rtl/bus_lane_packer_if.sv
// Bundle of the narrow input channel and the wide output channel.
//   slave  : packer side (consumes beats, produces words and occupancy)
//   master : environment side (drives beats, accepts words)
interface bus_lane_packer_if
  import bus_lane_packer_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int LANES = 4,
  parameter int DEPTH = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_W-1:0]           in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*IN_W-1:0]     out_data;
  logic [LANES-1:0]          out_keep;
  logic [clog2(DEPTH):0]     level;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, level
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, level
  );
endinterface

// File: rtl/bus_lane_packer_fifo.sv
// lane_word_fifo: generic synchronous FIFO with occupancy counter.
//   clk, rst_n        : clock, synchronous active-low reset
//   push, push_data   : write request (ignored when full)
//   pop, pop_data     : read request (ignored when empty); pop_data is the head
//   full, empty, level: status derived from an explicit occupancy counter
module lane_word_fifo
  import bus_lane_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);
  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Head is read asynchronously so a word is visible the cycle after its push.
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bus_lane_packer.sv
// bus_lane_packer: packs IN_W-bit beats into LANES*IN_W-bit words (lane 0 in
// the LSBs), pads early-closed words with PAD_VALUE and buffers finished
// words in a DEPTH-entry FIFO.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave modport carrying in_* beat channel, out_* word channel
//                and FIFO level
module bus_lane_packer
  import bus_lane_packer_pkg::*;
#(
  parameter int              IN_W      = 5,
  parameter int              LANES     = 4,
  parameter int              DEPTH     = 4,
  parameter logic [IN_W-1:0] PAD_VALUE = IN_W'(PAD_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_lane_packer_if.slave bus
);
  localparam int IDX_W  = clog2(LANES);
  localparam int WORD_W = LANES * IN_W;
  localparam int LVL_W  = clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  logic                         rst_n_q, rst_n_d;
  logic [LANES-1:0][IN_W-1:0]   acc_q, acc_d;
  logic [LANES-1:0]             keep_q, keep_d;
  logic [IDX_W-1:0]             idx_q, idx_d;

  logic [LANES-1:0][IN_W-1:0]   lane_word;
  logic [LANES-1:0]             lane_keep;
  logic                         accept, complete;
  logic                         fifo_full, fifo_empty;
  logic [WORD_W+LANES-1:0]      head;
  logic [LVL_W-1:0]             fifo_level;

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready = rst_n_q & ~fifo_full;
  assign accept       = bus.in_valid & bus.in_ready;
  assign complete     = accept & (bus.in_last | (idx_q == LAST_IDX));

  // Accumulator with the current beat merged in; this is both the next
  // accumulator value and the word pushed when the beat completes it.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic hit;
      assign hit           = accept && (idx_q == IDX_W'(gi));
      assign lane_word[gi] = hit ? bus.in_data : acc_q[gi];
      assign lane_keep[gi] = hit | keep_q[gi];
    end
  endgenerate

  always_comb begin
    rst_n_d = 1'b1;
    acc_d   = lane_word;
    keep_d  = lane_keep;
    idx_d   = idx_q;
    if (accept) idx_d = idx_q + 1'b1;
    if (complete) begin
      acc_d  = {LANES{PAD_VALUE}};
      keep_d = '0;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_n_q <= 1'b0;
      acc_q   <= {LANES{PAD_VALUE}};
      keep_q  <= '0;
      idx_q   <= '0;
    end else begin
      rst_n_q <= rst_n_d;
      acc_q   <= acc_d;
      keep_q  <= keep_d;
      idx_q   <= idx_d;
    end
  end

  lane_word_fifo #(
    .WIDTH (WORD_W + LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (complete),
    .push_data ({lane_keep, lane_word}),
    .pop       (bus.out_valid & bus.out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Stale RAM contents are hidden while the FIFO is empty.
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : head[WORD_W-1:0];
  assign bus.out_keep  = fifo_empty ? '0 : head[WORD_W +: LANES];
  assign bus.level     = fifo_level;

endmodule
